// File: rtl/midi_seq_trigger_mc.sv
// Channel-filtered MIDI byte FIFO feeding a fixed-latency trigger sequencer.
// Define SEQ_TRIG_SYSEX_EN to build the sysex handshake path (syx_cmd synchroniser, send/ready pulses).
`timescale 1ns/1ps
module midi_seq_trigger_mc #(
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TRIG_DLY   = 3
) (
    input  logic              reg_clk,
    input  logic              reset_reg_N,
    input  logic [3:0]        midi_ch,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              byteready,
    input  logic [7:0]        midibyte_nr,
    input  logic [7:0]        midi_in_data,
    input  logic              is_st_sysex,
    input  logic              syx_cmd,
    input  logic              dec_sysex_data_patch_send,
    input  logic              auto_syx_cmd,
    output logic [3:0]        cur_midi_ch,
    output logic [7:0]        midi_bytes,
    output logic [7:0]        seq_databyte,
    output logic              is_data_byte,
    output logic              is_velocity,
    output logic              trig__note_stack,
    output logic              trig_seq_f,
    output logic              midi_send_byte,
    output logic              syx_data_ready,
    output logic              fifo_full,
    output logic              overflow,
    output logic              busy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(TRIG_DLY);

    typedef enum logic [2:0] {IDLE, LOAD, DELAY, EMIT, GAP} state_t;

    typedef struct packed {
        logic [3:0] ch;
        logic [7:0] nr;
        logic [7:0] data;
        logic       sx;
    } entry_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dly_cnt;
    entry_t           mem [FIFO_DEPTH];
    entry_t           wr_entry, rd_entry;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             fifo_empty;
    logic             sysex_eff;
    logic [15:0]      ch_mask;
    logic             accept, push, pop;

    // Zero-extended mask makes channels >= NUM_CH read as disabled.
    assign ch_mask    = 16'(ch_enable);
    assign accept     = (byteready | midi_send_byte) & (ch_mask[midi_ch] | sysex_eff);
    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = accept & (~fifo_full | pop);
    assign wr_entry   = '{ch: midi_ch, nr: midibyte_nr, data: midi_in_data, sx: sysex_eff};
    assign rd_entry   = mem[rd_ptr];

    always_ff @(posedge reg_clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (accept && !push)   overflow <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                state_d = LOAD;
                pop     = 1'b1;
            end
            LOAD:  state_d = DELAY;
            DELAY: if (dly_cnt == '0) state_d = EMIT;
            EMIT:  state_d = GAP;
            GAP: begin
                if (!fifo_empty) begin
                    state_d = LOAD;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q <= IDLE;
            dly_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LOAD)                      dly_cnt <= CNT_W'(TRIG_DLY - 2);
            else if (state_q == DELAY && dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
        end
    end

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            cur_midi_ch  <= '0;
            midi_bytes   <= '0;
            seq_databyte <= '0;
            is_data_byte <= 1'b0;
            is_velocity  <= 1'b0;
        end else if (pop) begin
            cur_midi_ch  <= rd_entry.ch;
            midi_bytes   <= rd_entry.nr;
            seq_databyte <= rd_entry.data;
            is_data_byte <= rd_entry.nr[0];
            is_velocity  <= ~rd_entry.nr[0] & (rd_entry.nr != '0);
        end
    end

    assign trig__note_stack = (state_q == EMIT);
    assign trig_seq_f       = (state_q == GAP);
    assign busy             = (state_q != IDLE) | ~fifo_empty;

`ifdef SEQ_TRIG_SYSEX_EN
    logic syx_s1, syx_s2, syx_edge_q, send_q, last_dly;
    logic unused_sysex;

    assign sysex_eff    = is_st_sysex;
    assign last_dly     = (state_q == DELAY) & (dly_cnt == '0);
    assign unused_sysex = rd_entry.sx;

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            syx_s1     <= 1'b0;
            syx_s2     <= 1'b0;
            syx_edge_q <= 1'b0;
            send_q     <= 1'b0;
        end else begin
            syx_s1     <= syx_cmd;
            syx_s2     <= syx_s1;
            syx_edge_q <= syx_s1 & ~syx_s2;
            if (state_q == LOAD) send_q <= dec_sysex_data_patch_send;
        end
    end

    assign syx_data_ready = syx_edge_q | (last_dly & (dec_sysex_data_patch_send | auto_syx_cmd));
    assign midi_send_byte = (state_q == GAP) & send_q;
`else
    logic unused_sysex;

    assign sysex_eff      = 1'b0;
    assign syx_data_ready = 1'b0;
    assign midi_send_byte = 1'b0;
    assign unused_sysex   = &{1'b0, is_st_sysex, syx_cmd, dec_sysex_data_patch_send,
                              auto_syx_cmd, rd_entry.sx};
`endif

endmodule

// File: tb/tb_midi_seq_trigger_mc.sv
// Directed bench for midi_seq_trigger_mc: vector table for single events plus FIFO, reset and sysex sequences.
`timescale 1ns/1ps
module tb_midi_seq_trigger_mc;
    localparam int unsigned TRIG_DLY = 3;
`ifdef SEQ_TRIG_SYSEX_EN
    localparam bit SYSEX = 1'b1;
`else
    localparam bit SYSEX = 1'b0;
`endif

    logic        reg_clk, reset_reg_N;
    logic [3:0]  midi_ch;
    logic [15:0] ch_enable;
    logic        byteready;
    logic [7:0]  midibyte_nr, midi_in_data;
    logic        is_st_sysex, syx_cmd, dec_sysex_data_patch_send, auto_syx_cmd;
    logic [3:0]  cur_midi_ch;
    logic [7:0]  midi_bytes, seq_databyte;
    logic        is_data_byte, is_velocity, trig__note_stack, trig_seq_f;
    logic        midi_send_byte, syx_data_ready, fifo_full, overflow, busy;

    midi_seq_trigger_mc #(.NUM_CH(16), .FIFO_DEPTH(4), .TRIG_DLY(TRIG_DLY)) dut (
        .reg_clk(reg_clk), .reset_reg_N(reset_reg_N), .midi_ch(midi_ch), .ch_enable(ch_enable),
        .byteready(byteready), .midibyte_nr(midibyte_nr), .midi_in_data(midi_in_data),
        .is_st_sysex(is_st_sysex), .syx_cmd(syx_cmd),
        .dec_sysex_data_patch_send(dec_sysex_data_patch_send), .auto_syx_cmd(auto_syx_cmd),
        .cur_midi_ch(cur_midi_ch), .midi_bytes(midi_bytes), .seq_databyte(seq_databyte),
        .is_data_byte(is_data_byte), .is_velocity(is_velocity),
        .trig__note_stack(trig__note_stack), .trig_seq_f(trig_seq_f),
        .midi_send_byte(midi_send_byte), .syx_data_ready(syx_data_ready),
        .fifo_full(fifo_full), .overflow(overflow), .busy(busy)
    );

    typedef struct {
        logic [3:0]  ch;
        logic [15:0] en;
        logic [7:0]  nr;
        logic [7:0]  data;
        logic        sx;
        logic        acc;
        logic        isd;
        logic        vel;
    } vec_t;

    vec_t       vecs [8];
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    bit         mon_space = 1'b1;
    int         mon_n = 0;
    int         mon_prev = 0;
    logic [7:0] exp_q [$];

    initial reg_clk = 1'b0;
    always #5 reg_clk = ~reg_clk;
    always @(posedge reg_clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [28:0] outs();
        return {cur_midi_ch, midi_bytes, seq_databyte, is_data_byte, is_velocity, trig__note_stack,
                trig_seq_f, midi_send_byte, syx_data_ready, fifo_full, overflow, busy};
    endfunction

    task automatic step();
        @(posedge reg_clk);
        #1;
    endtask

    // Background pulse monitor: data order and, when enabled, pulse spacing.
    always @(negedge reg_clk) begin
        if (mon_en && trig__note_stack) begin
            if (exp_q.size() == 0) check("extra_trig", 1, 0);
            else check("trig_data", seq_databyte, exp_q.pop_front());
            if (mon_space && mon_n > 0) check("trig_spacing", cyc - mon_prev, TRIG_DLY + 2);
            mon_prev = cyc;
            mon_n++;
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int trig_at, trig_cnt, gap_at;
        midi_ch = v.ch; ch_enable = v.en; midibyte_nr = v.nr; midi_in_data = v.data;
        is_st_sysex = v.sx; byteready = 1'b1;
        step();
        byteready = 1'b0; is_st_sysex = 1'b0;
        trig_at = -1; trig_cnt = 0; gap_at = -1;
        for (int r = 1; r <= 12; r++) begin
            if (r == 1) check($sformatf("v%0d_busy", idx), busy, v.acc);
            if (trig__note_stack) begin
                trig_cnt++;
                trig_at = r;
                check($sformatf("v%0d_data", idx), seq_databyte, v.data);
                check($sformatf("v%0d_nr", idx), midi_bytes, v.nr);
                check($sformatf("v%0d_ch", idx), cur_midi_ch, v.ch);
                check($sformatf("v%0d_isdata", idx), is_data_byte, v.isd);
                check($sformatf("v%0d_isvel", idx), is_velocity, v.vel);
            end
            if (trig_seq_f && gap_at < 0) gap_at = r;
            step();
        end
        check($sformatf("v%0d_trig_count", idx), trig_cnt, v.acc ? 1 : 0);
        if (v.acc) begin
            check($sformatf("v%0d_trig_cycle", idx), trig_at, 2 + TRIG_DLY);
            check($sformatf("v%0d_gap_cycle", idx), gap_at, 3 + TRIG_DLY);
        end
        check($sformatf("v%0d_busy_end", idx), busy, 0);
    endtask

    initial begin
        vecs[0] = '{4'd0,  16'h0001, 8'h01, 8'h3C, 1'b0, 1'b1,  1'b1, 1'b0};
        vecs[1] = '{4'd5,  16'h0001, 8'h02, 8'h40, 1'b0, 1'b0,  1'b0, 1'b0};
        vecs[2] = '{4'd5,  16'h0020, 8'h02, 8'h40, 1'b0, 1'b1,  1'b0, 1'b1};
        vecs[3] = '{4'd15, 16'h8000, 8'h00, 8'h7F, 1'b0, 1'b1,  1'b0, 1'b0};
        vecs[4] = '{4'd3,  16'hFFF7, 8'h03, 8'h11, 1'b0, 1'b0,  1'b0, 1'b0};
        vecs[5] = '{4'd9,  16'hFFFF, 8'h80, 8'h00, 1'b0, 1'b1,  1'b0, 1'b1};
        vecs[6] = '{4'd2,  16'hFFFF, 8'hFF, 8'hA5, 1'b0, 1'b1,  1'b1, 1'b0};
        vecs[7] = '{4'd6,  16'h0001, 8'h04, 8'h09, 1'b1, SYSEX, 1'b0, 1'b1};

        reset_reg_N = 1'b0; midi_ch = '0; ch_enable = 16'h0001; byteready = 1'b0;
        midibyte_nr = '0; midi_in_data = '0; is_st_sysex = 1'b0; syx_cmd = 1'b0;
        dec_sysex_data_patch_send = 1'b0; auto_syx_cmd = 1'b0;
        repeat (2) @(posedge reg_clk);
        #1;
        check("reset_outputs", outs(), 0);
        reset_reg_N = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Fill to full, skip the dropping cycle, then push during the GAP pop.
        midi_ch = 4'd0; ch_enable = 16'h0001; midibyte_nr = 8'h01;
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(8'h10 + i));
        mon_n = 0; mon_space = 1'b1; mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            midi_in_data = 8'(8'h10 + i); byteready = 1'b1;
            step();
        end
        byteready = 1'b0;
        check("pp_full_before", fifo_full, 1);
        step();
        check("pp_gap", trig_seq_f, 1);
        check("pp_full_gap", fifo_full, 1);
        midi_in_data = 8'h15; byteready = 1'b1;
        step();
        byteready = 1'b0;
        check("pp_full_after", fifo_full, 1);
        check("pp_no_overflow", overflow, 0);
        repeat (30) step();
        check("pp_trig_count", mon_n, 6);
        check("pp_queue_empty", exp_q.size(), 0);
        check("pp_idle", busy, 0);
        mon_en = 1'b0;

        // Six back-to-back accepts: one drains into the FSM, four buffer, the sixth drops.
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h20 + i));
        mon_n = 0; mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            midi_in_data = 8'(8'h20 + i); byteready = 1'b1;
            if (i == 5) begin
                check("ovf_full", fifo_full, 1);
                check("ovf_not_yet", overflow, 0);
            end
            step();
        end
        byteready = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_full_hold", fifo_full, 1);
        repeat (30) step();
        check("ovf_trig_count", mon_n, 5);
        check("ovf_queue_empty", exp_q.size(), 0);
        check("ovf_sticky", overflow, 1);
        check("ovf_drained", fifo_full, 0);
        check("ovf_idle", busy, 0);
        mon_en = 1'b0;

        // Asynchronous reset in the middle of DELAY.
        midi_in_data = 8'h77; midibyte_nr = 8'h05; byteready = 1'b1;
        step();
        byteready = 1'b0;
        step();
        step();
        check("mid_busy", busy, 1);
        check("mid_loaded", midi_bytes, 8'h05);
        #2;
        reset_reg_N = 1'b0;
        #1;
        check("mid_reset_outputs", outs(), 0);
        step();
        reset_reg_N = 1'b1;
        begin
            int n;
            n = 0;
            repeat (12) begin
                if (trig__note_stack) n++;
                step();
            end
            check("mid_no_trig", n, 0);
        end
        run_vec(vecs[0], 8);

        // Sysex: synchroniser edge pulse, last-DELAY ready pulse, GAP send and re-accept.
        syx_cmd = 1'b1;
        step();
        check("syx_c1", syx_data_ready, 0);
        step();
        check("syx_c2", syx_data_ready, SYSEX);
        step();
        check("syx_c3", syx_data_ready, 0);
        syx_cmd = 1'b0;
        step();
        exp_q.push_back(8'h55);
        if (SYSEX) exp_q.push_back(8'h66);
        mon_n = 0; mon_space = 1'b0; mon_en = 1'b1;
        midi_in_data = 8'h55; midibyte_nr = 8'h01; dec_sysex_data_patch_send = 1'b1; byteready = 1'b1;
        step();
        byteready = 1'b0; midi_in_data = 8'h66; midibyte_nr = 8'h02;
        step();
        step();
        dec_sysex_data_patch_send = 1'b0; auto_syx_cmd = 1'b1;
        check("syx_first_delay", syx_data_ready, 0);
        step();
        check("syx_last_delay", syx_data_ready, SYSEX);
        auto_syx_cmd = 1'b0;
        step();
        step();
        check("syx_send_gap", midi_send_byte, SYSEX);
        repeat (15) step();
        check("syx_trig_count", mon_n, 1 + SYSEX);
        check("syx_queue_empty", exp_q.size(), 0);
        check("syx_idle", busy, 0);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
